// File: rtl/regfile_port_sched.sv
// Schedules a single-port register file between a two-operand decode reader
// and a writeback writer, with late-write forwarding into held operands and x0 hardwired.
module regfile_port_sched #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_req_valid,
  output logic            rd_req_ready,
  input  logic [REGW-1:0] rs1,
  input  logic [REGW-1:0] rs2,
  output logic            rd_rsp_valid,
  input  logic            rd_rsp_ready,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [REGW-1:0] rf_regno,
  output logic            rf_read,
  output logic            rf_write,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [XLEN-1:0] rf_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RS1  = 3'd1;
  localparam logic [2:0] S_RS2  = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [REGW-1:0] rs1_q, rs1_d;
  logic [REGW-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;

  logic wb_fire;
  logic rs1_hit;
  logic rs2_hit;

  // Port-side outputs; reset forces every strobe and handshake low.
  always_comb begin
    rd_req_ready = !rst && (state_q == S_IDLE);
    wb_ready     = !rst && ((state_q == S_IDLE) || (state_q == S_CAP) ||
                            (state_q == S_RESP));
    rf_read      = !rst && ((state_q == S_RS1) || (state_q == S_RS2));
    wb_fire      = wb_valid && wb_ready;
    rf_write     = wb_fire && (wb_rd != '0);
    rf_wdata     = wb_fire ? wb_data : '0;
    rf_regno     = '0;
    if (rf_read) begin
      rf_regno = (state_q == S_RS1) ? rs1_q : rs2_q;
    end else if (wb_fire) begin
      rf_regno = wb_rd;
    end
    rd_rsp_valid = !rst && (state_q == S_RESP);
    rs1_data     = rst ? '0 : rs1_data_q;
    rs2_data     = rst ? '0 : rs2_data_q;
  end

  assign rs1_hit = wb_fire && (wb_rd == rs1_q) && (rs1_q != '0);
  assign rs2_hit = wb_fire && (wb_rd == rs2_q) && (rs2_q != '0);

  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    case (state_q)
      S_IDLE: begin
        if (rd_req_valid && rd_req_ready) begin
          rs1_d   = rs1;
          rs2_d   = rs2;
          state_d = S_RS1;
        end
      end
      S_RS1: begin
        state_d = S_RS2;
      end
      S_RS2: begin
        rs1_data_d = (rs1_q == '0) ? '0 : rf_rdata;
        state_d    = S_CAP;
      end
      S_CAP: begin
        // rs2 captures this edge, so a same-cycle write must beat the stale read data.
        if (rs2_hit) begin
          rs2_data_d = wb_data;
        end else begin
          rs2_data_d = (rs2_q == '0) ? '0 : rf_rdata;
        end
        if (rs1_hit) begin
          rs1_data_d = wb_data;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rs1_hit) begin
          rs1_data_d = wb_data;
        end
        if (rs2_hit) begin
          rs2_data_d = wb_data;
        end
        if (rd_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_port_sched.sv
// Scoreboard bench: an architectural register model supplies expected operands
// when a response is consumed; directed scenarios followed by random traffic.
module tb_regfile_port_sched;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            rd_req_valid, rd_req_ready;
  logic [REGW-1:0] rs1, rs2;
  logic            rd_rsp_valid, rd_rsp_ready;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            wb_valid, wb_ready;
  logic [REGW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [REGW-1:0] rf_regno;
  logic            rf_read, rf_write;
  logic [XLEN-1:0] rf_wdata, rf_rdata;

  always #5 clk = ~clk;

  regfile_port_sched #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rs1(rs1), .rs2(rs2),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_regno(rf_regno), .rf_read(rf_read), .rf_write(rf_write),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  typedef struct {
    logic [REGW-1:0] a;
    logic [REGW-1:0] b;
  } req_t;

  logic [XLEN-1:0] mem  [32];
  logic [XLEN-1:0] arch [32];
  req_t            pend [$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit awaiting = 1'b0;
  int stall = 0;
  int consumed = 0;

  function automatic logic [XLEN-1:0] init_val(input int i);
    if (i == 0) return 32'hBAD0_BAD0;
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Register file: registered read data, junk whenever no read is issued.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (rf_write) begin
      mem[rf_regno] <= rf_wdata;
    end
    rf_rdata <= rf_read ? mem[rf_regno] : $urandom;
  end

  // Monitor: operands must equal the current architectural value at consumption.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend.delete();
      awaiting = 1'b0;
      stall = 0;
      for (int i = 0; i < 32; i++) arch[i] = (i == 0) ? '0 : init_val(i);
    end else begin
      check("rf_read_write_exclusive", 32'(rf_read && rf_write), 32'd0);
      if (wb_valid && wb_ready) begin
        check("rf_write_strobe", 32'(rf_write), 32'(wb_rd != '0));
        check("rf_regno_wb", 32'(rf_regno), 32'(wb_rd));
        check("rf_wdata_wb", rf_wdata, wb_data);
      end else begin
        check("rf_wdata_idle", rf_wdata, '0);
        check("rf_write_idle", 32'(rf_write), 32'd0);
      end
      if (wb_valid && !wb_ready) stall++;
      else stall = 0;
      if (stall > 2) check("wb_stall_bound", 32'(stall), 32'd2);
      if (awaiting && rd_rsp_valid) begin
        check("latency", 32'(cyc - acc_cyc), 32'd4);
        awaiting = 1'b0;
      end
      if (rd_rsp_valid && rd_rsp_ready) begin
        if (pend.size() == 0) begin
          timeout("rsp_without_request");
        end else begin
          req_t e;
          e = pend.pop_front();
          check("rs1_data", rs1_data, arch[e.a]);
          check("rs2_data", rs2_data, arch[e.b]);
        end
        consumed++;
      end
      if (wb_valid && wb_ready && wb_rd != '0) arch[wb_rd] = wb_data;
      if (rd_req_valid && rd_req_ready) begin
        pend.push_back('{a: rs1, b: rs2});
        acc_cyc = cyc;
        awaiting = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [REGW-1:0] rd, input logic [XLEN-1:0] d);
    bit got = 1'b0;
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wb_ready) begin got = 1'b1; break; end
    end
    if (!got) timeout("write_accept");
    else check("wb_x_rf_write", 32'(rf_write), 32'(rd != '0));
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic do_req(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
    bit got = 1'b0;
    rd_req_valid = 1'b1; rs1 = a; rs2 = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_req_ready) begin got = 1'b1; break; end
    end
    if (!got) timeout("req_accept");
    tick();
    rd_req_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_rsp_valid) begin got = 1'b1; break; end
    end
    if (!got) timeout("rsp_valid");
    tick();
  endtask

  task automatic wait_consume();
    int start = consumed;
    bit got = 1'b0;
    rd_rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (consumed != start) begin got = 1'b1; break; end
    end
    if (!got) timeout("rsp_consume");
    rd_rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_req_valid = 1'b1; rs1 = '0; rs2 = '0; rd_rsp_ready = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1111_1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd_req_ready", 32'(rd_req_ready), 32'd0);
    check("rst_wb_ready", 32'(wb_ready), 32'd0);
    check("rst_rf_read", 32'(rf_read), 32'd0);
    check("rst_rf_write", 32'(rf_write), 32'd0);
    check("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("rst_rs1_data", rs1_data, '0);
    check("rst_rs2_data", rs2_data, '0);
    tick();
    rst = 1'b0; rd_req_valid = 1'b0; wb_valid = 1'b0;
    tick();

    // Basic read with cycle-by-cycle port timing
    do_write(5'd5, 32'hDEAD_BEEF);
    do_write(5'd6, 32'h1234_5678);
    rd_req_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd6;
    @(negedge clk);
    check("idle_req_ready", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("rf_read_window", 32'(rf_read), 32'(k <= 2));
      check("rsp_valid_window", 32'(rd_rsp_valid), 32'(k == 4));
      if (k == 4) begin
        check("x5_operand", rs1_data, 32'hDEAD_BEEF);
        check("x6_operand", rs2_data, 32'h1234_5678);
      end
      tick();
    end
    wait_consume();

    // x0 write dropped, x0 reads as zero
    do_write(5'd0, 32'hFFFF_FFFF);
    do_req(5'd0, 5'd0);
    wait_valid();
    check("x0_rs1", rs1_data, '0);
    check("x0_rs2", rs2_data, '0);
    wait_consume();

    // Writeback stalls through RS1/RS2 and commits in CAP
    rd_req_valid = 1'b1; rs1 = 5'd3; rs2 = 5'd4;
    tick();
    rd_req_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h7777_0007;
    @(negedge clk);
    check("wb_ready_rs1", 32'(wb_ready), 32'd0);
    tick();
    @(negedge clk);
    check("wb_ready_rs2", 32'(wb_ready), 32'd0);
    tick();
    @(negedge clk);
    check("wb_ready_cap", 32'(wb_ready), 32'd1);
    check("cap_rf_write", 32'(rf_write), 32'd1);
    check("cap_rf_regno", 32'(rf_regno), 32'd7);
    tick();
    wb_valid = 1'b0;
    wait_consume();
    do_req(5'd7, 5'd3);
    wait_valid();
    check("x7_readback", rs1_data, 32'h7777_0007);
    wait_consume();

    // Same-cycle write and request in IDLE
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hA5A5_A5A5;
    rd_req_valid = 1'b1; rs1 = 5'd9; rs2 = 5'd9;
    @(negedge clk);
    check("both_ready_idle", 32'({rd_req_ready, wb_ready}), 32'd3);
    tick();
    wb_valid = 1'b0; rd_req_valid = 1'b0;
    wait_valid();
    check("same_cycle_rs1", rs1_data, 32'hA5A5_A5A5);
    check("same_cycle_rs2", rs2_data, 32'hA5A5_A5A5);
    wait_consume();

    // Forwarding into a held response
    do_req(5'd9, 5'd3);
    wait_valid();
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0055;
    @(negedge clk);
    check("wb_ready_resp", 32'(wb_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    check("resp_fwd_rs1", rs1_data, 32'h0000_0055);
    check("resp_keep_rs2", rs2_data, arch[3]);
    check("resp_valid_held", 32'(rd_rsp_valid), 32'd1);
    tick();
    @(negedge clk);
    check("resp_valid_held2", 32'(rd_rsp_valid), 32'd1);
    tick();
    wait_consume();

    // Reset during RS2 abandons the request
    rd_req_valid = 1'b1; rs1 = 5'd1; rs2 = 5'd2;
    tick();
    rd_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_rf_read", 32'(rf_read), 32'd0);
    check("rst_mid_req_ready", 32'(rd_req_ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(rd_req_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("post_rst_rf_read", 32'(rf_read), 32'd0);
    check("post_rst_rs1", rs1_data, '0);
    check("post_rst_rs2", rs2_data, '0);
    tick();
    do_req(5'd5, 5'd6);
    wait_consume();

    // Random traffic with small index range to provoke hazards
    repeat (600) begin
      rd_req_valid = ($urandom_range(0, 2) == 0);
      rs1 = REGW'($urandom_range(0, 7));
      rs2 = REGW'($urandom_range(0, 7));
      wb_valid = 1'($urandom_range(0, 1));
      wb_rd = REGW'($urandom_range(0, 7));
      wb_data = $urandom;
      rd_rsp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    rd_req_valid = 1'b0; wb_valid = 1'b0; rd_rsp_ready = 1'b1;
    repeat (10) tick();
    check("drain_empty", 32'(pend.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
